// File: rtl/microseq_pkg.sv
// Shared constants for the microprogram sequencer: next-address modes,
// condition-source indices and control-store field positions.
package microseq_pkg;

  localparam logic [2:0] ENC   = 3'b000;
  localparam logic [2:0] FETCH = 3'b001;
  localparam logic [2:0] JUMP  = 3'b010;
  localparam logic [2:0] INC   = 3'b011;
  localparam logic [2:0] CBR   = 3'b100;
  localparam logic [2:0] CENC  = 3'b101;
  localparam logic [2:0] CALL  = 3'b110;
  localparam logic [2:0] RET   = 3'b111;

  localparam int COND_MOC  = 0;
  localparam int COND_PASS = 1;
  localparam int COND_LSM  = 2;
  localparam int COND_SHF  = 3;

  // Control-store word bit positions, shared with the ROM wrapper
  localparam int ROM_N_HI  = 57;
  localparam int ROM_N_LO  = 55;
  localparam int ROM_INV   = 54;
  localparam int ROM_MI    = 53;
  localparam int ROM_S_HI  = 52;
  localparam int ROM_S_LO  = 50;
  localparam int ROM_CR_HI = 41;
  localparam int ROM_CR_LO = 34;

  localparam int ADDR_W = 8;

endpackage

// File: rtl/microseq_stack.sv
// Return-address LIFO for microroutine calls; push/pop take effect on the
// clock edge, overflow/underflow attempts are dropped and latched sticky.
module microseq_stack
  import microseq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = ADDR_W,
  localparam int AW   = $clog2(DEPTH),
  localparam int DW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  push_dat_i,
  output logic [W-1:0]  top_dat_o,
  output logic          empty_o,
  output logic [DW-1:0] depth_o,
  output logic          ovf_o,
  output logic          unf_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [DW-1:0] depth_q, depth_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic [DW-1:0] top_idx;
  logic          full;
  logic          empty;
  logic          do_push;

  assign full    = (depth_q == DW'(DEPTH));
  assign empty   = (depth_q == '0);
  assign top_idx = depth_q - DW'(1);
  assign do_push = push_i && !full;

  always_comb begin
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (push_i) begin
      if (full) ovf_d = 1'b1;
      else      depth_d = depth_q + DW'(1);
    end else if (pop_i) begin
      if (empty) unf_d = 1'b1;
      else       depth_d = depth_q - DW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      if (do_push) mem_q[depth_q[AW-1:0]] <= push_dat_i;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign top_dat_o = mem_q[top_idx[AW-1:0]];
  assign empty_o   = empty;
  assign depth_o   = depth_q;
  assign ovf_o     = ovf_q;
  assign unf_o     = unf_q;

endmodule

// File: rtl/microseq_ctrl.sv
// Microprogram sequencer: owns the control-store address and selects the next
// one from the ROM next-state fields, one cycle per advance, frozen by stall.
module microseq_ctrl
  import microseq_pkg::*;
#(
  parameter logic [7:0] RESET_ADDR = 8'd0,
  parameter logic [7:0] FETCH_ADDR = 8'd1,
  parameter int         STK_DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       stall,
  input  logic [2:0]                 n_sel,
  input  logic                       inv,
  input  logic                       mi,
  input  logic [2:0]                 s_sel,
  input  logic [7:0]                 cr,
  input  logic [7:0]                 cond_vec,
  input  logic [7:0]                 enc_addr,
  output logic [7:0]                 state,
  output logic                       cond_taken,
  output logic [$clog2(STK_DEPTH):0] stk_depth,
  output logic                       stk_ovf,
  output logic                       stk_unf
);

  logic [7:0] state_q, state_d;
  logic       cond_q;
  logic       cond_c;
  logic [7:0] inc_addr;
  logic       push, pop;
  logic [7:0] stk_top;
  logic       stk_empty;

  assign cond_c   = (mi ? 1'b1 : cond_vec[s_sel]) ^ inv;
  assign inc_addr = state_q + 8'd1;

  // Stack moves only on advancing cycles; a CALL whose condition fails is a plain step
  assign push = !stall && (n_sel == CALL) && cond_c;
  assign pop  = !stall && (n_sel == RET);

  always_comb begin
    state_d = state_q;
    case (n_sel)
      ENC:     state_d = enc_addr;
      FETCH:   state_d = FETCH_ADDR;
      JUMP:    state_d = cr;
      INC:     state_d = inc_addr;
      CBR:     state_d = cond_c ? cr : inc_addr;
      CENC:    state_d = cond_c ? cr : enc_addr;
      CALL:    state_d = cond_c ? cr : inc_addr;
      RET:     state_d = stk_empty ? FETCH_ADDR : stk_top;
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RESET_ADDR;
      cond_q  <= 1'b0;
    end else if (!stall) begin
      state_q <= state_d;
      cond_q  <= cond_c;
    end
  end

  microseq_stack #(
    .DEPTH (STK_DEPTH),
    .W     (8)
  ) u_stack (
    .clk        (clk),
    .reset_n    (reset_n),
    .push_i     (push),
    .pop_i      (pop),
    .push_dat_i (inc_addr),
    .top_dat_o  (stk_top),
    .empty_o    (stk_empty),
    .depth_o    (stk_depth),
    .ovf_o      (stk_ovf),
    .unf_o      (stk_unf)
  );

  assign state      = state_q;
  assign cond_taken = cond_q;

endmodule

// File: doc/microseq_ctrl.md
Name: microseq_ctrl

Overview:
- Microprogram sequencer for the 256×64 control-store ROM of the ARM control unit.
- Holds the current microstate (the ROM address) and computes the next address from the ROM's next-state fields: N2-N0 (next-address mode), INV, MI, S2-S0 (condition select) and CR7-CR0 (branch target).
- Adds a small return-address stack so that shared microroutines (memory wait, LSM loops) can be called and returned from.
- Sits between the ROM output pipeline and the ROM address input; it is the only writer of the ROM address.

Parameters:
- RESET_ADDR, 8'd0, microstate loaded on reset.
- FETCH_ADDR, 8'd1, microstate targeted by FETCH mode and by a return-stack underflow.
- STK_DEPTH, 4, number of return-stack entries (power of two, 2..16).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- stall  in  1  when 1, every internal register holds.
- n_sel  in  3  ROM bits 57-55 (N2-N0), next-address mode.
- inv  in  1  ROM bit 54, inverts the selected condition.
- mi  in  1  ROM bit 53, forces the raw condition to 1.
- s_sel  in  3  ROM bits 52-50 (S2-S0), condition-source select.
- cr  in  8  ROM bits 41-34 (CR7-CR0), branch/call target.
- cond_vec  in  8  condition sources: bit0 MOC, bit1 ARM condition-pass, bit2 LSM done, bit3 shifter-needed, bits 7-4 spare (tie 0).
- enc_addr  in  8  entry address from the instruction encoder.
- state  out  8  current microstate; drives the ROM IN port.
- cond_taken  out  1  registered evaluated condition of the last advancing cycle.
- stk_depth  out  clog2(STK_DEPTH)+1  number of valid stack entries.
- stk_ovf  out  1  sticky: a push was attempted while the stack was full.
- stk_unf  out  1  sticky: a pop was attempted while the stack was empty.

Behaviour:
- Async reset (reset_n=0):
  - state=RESET_ADDR, cond_taken=0, stk_depth=0, stk_ovf=0, stk_unf=0.
  - All stack entries cleared to 0.
- Release of reset is synchronous to clk. The first advance happens at the first rising edge with reset_n=1 and stall=0.
- Condition evaluation is combinational: c = (mi ? 1 : cond_vec[s_sel]) ^ inv.
- Increment: inc = state + 1, modulo 256 (255 -> 0, no flag).
- Next-address modes, all registered on the rising edge, latency 1 cycle:
  - 000 ENC: next = enc_addr.
  - 001 FETCH: next = FETCH_ADDR.
  - 010 JUMP: next = cr.
  - 011 INC: next = inc.
  - 100 CBR: next = c ? cr : inc. A wait loop is written as cr = state.
  - 101 CENC: next = c ? cr : enc_addr.
  - 110 CALL: if c, push inc and next = cr; else next = inc with no push.
  - 111 RET: pop and next = top of stack.
- Stack is LIFO; top = entry[stk_depth-1].
- Push when full: the push is discarded, next = cr still, stk_ovf is set, and stk_depth stays at STK_DEPTH.
- Pop when empty: next = FETCH_ADDR, stk_unf is set, and stk_depth stays 0.
- stall=1: state, stack, depth, cond_taken and the flags all hold. No push or pop occurs, and the inputs are ignored.
- cond_taken is updated to c on every non-stalled edge, regardless of mode.
- Sticky flags are cleared only by reset_n.
- Reset asserted mid-CALL or mid-RET: reset wins. The stack is emptied and no partial push or pop survives.
- Inputs are sampled only at the clock edge; changes between edges have no effect.

Decomposition:
- Shared package `microseq_pkg` holds:
  - the N-mode constants ENC, FETCH, JUMP, INC, CBR, CENC, CALL, RET;
  - the cond_vec bit indices (COND_MOC, COND_PASS, COND_LSM, COND_SHF);
  - the ROM field bit positions (N 57:55, INV 54, MI 53, S 52:50, CR 41:34), so the ROM wrapper and the sequencer agree.
- One sub-module, `microseq_stack`: a parameterised LIFO with push/pop/full/empty/depth and sticky ovf/unf.
- The next-address mux and condition logic stay in the top level.

Test Plan:
- Reset and step:
  - Stimulus: reset_n low then high; n_sel=011 for 3 cycles.
  - Response: state 0 during reset, then 1, 2, 3; cond_taken 0; flags 0.
- Wait loop:
  - Stimulus: state=8'd30, n_sel=100, s_sel=000, inv=1, cr=30; hold cond_vec[0]=0 for 4 cycles, then set it to 1.
  - Response: state stays 30 for 4 cycles, then moves to 31.
- Decode dispatch:
  - Stimulus: n_sel=101, mi=0, inv=0, s_sel=001, cond_vec[1]=0, enc_addr=8'd25.
  - Response: next state=25, cond_taken=0.
  - Stimulus: repeat with cond_vec[1]=1, cr=8'd44.
  - Response: next state=44.
- Call/return nesting:
  - Stimulus: from state 10, CALL with cr=40, mi=1; then from 40, CALL with cr=50; then RET; then RET.
  - Response: states 40, 50, 41, 11; stk_depth 1, 2, 1, 0.
- Overflow/underflow:
  - Stimulus: five successive calls with STK_DEPTH=4.
  - Response: stk_ovf=1 after the 5th call; depth=4; five RETs yield the four pushed addresses, then FETCH_ADDR=1 with stk_unf=1.
- Stall and reset:
  - Stimulus: assert stall during a CALL.
  - Response: state, depth and cond_taken unchanged.
  - Stimulus: drop reset_n asynchronously mid-sequence (between edges).
  - Response: state=0 and depth=0 immediately, before the next clock edge.
